// File: rtl/button_counter_pkg.sv
// Shared types, constants and count-step helpers for the push-button counter.
package button_counter_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] HEX_MAX = 16'hFFFF;
  localparam logic [DATA_W-1:0] BCD_MAX = 16'h9999;

  // Auto-repeat controller states shared by the up and down buttons.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  // Result of one +/-1 step: new count and whether it wrapped.
  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              wrap;
  } step_t;

  // Binary +/-1 modulo 2^16.
  function automatic step_t hex_step(input logic [DATA_W-1:0] v, input logic down);
    step_t r;
    r = '0;
    if (down) begin
      r.val  = v - 16'd1;
      r.wrap = (v == 16'h0000);
    end else begin
      r.val  = v + 16'd1;
      r.wrap = (v == HEX_MAX);
    end
    return r;
  endfunction

  // Four-digit decimal +/-1 with ripple carry/borrow. Out-of-range nibbles are
  // folded back into 0-9 first so the result always holds legal digits.
  function automatic step_t bcd_step(input logic [DATA_W-1:0] v, input logic down);
    step_t      r;
    logic [3:0] nib;
    logic       c;
    r = '0;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nib = v[i*4 +: 4];
      if (nib > 4'd9) nib = nib - 4'd10;
      if (c) begin
        if (down) begin
          if (nib == 4'd0) nib = 4'd9;
          else begin
            nib = nib - 4'd1;
            c   = 1'b0;
          end
        end else begin
          if (nib == 4'd9) nib = 4'd0;
          else begin
            nib = nib + 4'd1;
            c   = 1'b0;
          end
        end
      end
      r.val[i*4 +: 4] = nib;
    end
    // A borrow out of the top digit lands on the top of the decimal range.
    if (c && down) r.val = BCD_MAX;
    r.wrap = c;
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stability-counter debouncer and rising-edge pulse
// for one raw push-button.
module button_debounce
  import button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          db_q;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has held steadily; any return restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (sync_p1 != db) begin
      if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        db  <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // One-cycle pulse on the registered 0->1 transition of the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= 1'b0;
      press <= 1'b0;
    end else begin
      db_q  <= db;
      press <= db & ~db_q;
    end
  end

endmodule

// File: rtl/button_counter.sv
// Push-button up/down/clear counter with auto-repeat, feeding a 4-digit
// hex display. Counts in binary or four-digit BCD.
module button_counter
  import button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter int BCD             = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_clr,
  output logic [15:0] dataword,
  output logic        wrap
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX);

  logic up_db, up_press, dn_db, dn_press, clr_db, clr_press;
  logic up_db_q, dn_db_q;

  rep_state_t    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          dir_dn, dir_n;
  logic          step, step_dn;
  logic          held_db, other_rise;
  step_t         step_res;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .db(up_db), .press(up_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .btn(btn_down), .db(dn_db), .press(dn_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .btn(btn_clr), .db(clr_db), .press(clr_press)
  );

  // Delayed debounced levels so a new opposite-direction press can be seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_db_q <= 1'b0;
      dn_db_q <= 1'b0;
    end else begin
      up_db_q <= up_db;
      dn_db_q <= dn_db;
    end
  end

  assign held_db    = dir_dn ? dn_db : up_db;
  assign other_rise = dir_dn ? (up_db & ~up_db_q) : (dn_db & ~dn_db_q);

  // Repeat controller: first step on press, then delayed and periodic steps.
  always_comb begin
    state_n = state;
    timer_n = timer;
    dir_n   = dir_dn;
    step    = 1'b0;
    step_dn = dir_dn;
    if (clr_db) begin
      state_n = ST_IDLE;
      timer_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer_n = '0;
          if (up_press ^ dn_press) begin
            step    = 1'b1;
            step_dn = dn_press;
            dir_n   = dn_press;
            state_n = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (!held_db || other_rise) begin
            state_n = ST_IDLE;
            timer_n = '0;
          end else if (timer == TW'(REPEAT_DELAY - 1)) begin
            step    = 1'b1;
            state_n = ST_REPEAT;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!held_db || other_rise) begin
            state_n = ST_IDLE;
            timer_n = '0;
          end else if (timer == TW'(REPEAT_PERIOD - 1)) begin
            step    = 1'b1;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          timer_n = '0;
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      timer  <= '0;
      dir_dn <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      dir_dn <= dir_n;
    end
  end

  // Next count for a step in the current direction.
  always_comb begin
    step_res = (BCD != 0) ? bcd_step(dataword, step_dn) : hex_step(dataword, step_dn);
  end

  // Registered count and wrap pulse; clear overrides any step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataword <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_press) begin
        dataword <= '0;
      end else if (step) begin
        dataword <= step_res.val;
        wrap     <= step_res.wrap;
      end
    end
  end

endmodule

// File: tb/tb_button_counter.sv
module tb_button_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_down, btn_clr;
  logic [15:0] dw_hex, dw_bcd;
  logic        wrap_hex, wrap_bcd;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  button_counter #(.DEBOUNCE_CYCLES(8), .REPEAT_DELAY(40), .REPEAT_PERIOD(10), .BCD(0)) dut_hex (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .dataword(dw_hex), .wrap(wrap_hex)
  );

  button_counter #(.DEBOUNCE_CYCLES(8), .REPEAT_DELAY(40), .REPEAT_PERIOD(10), .BCD(1)) dut_bcd (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .dataword(dw_bcd), .wrap(wrap_bcd)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Wait n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    tick(20);
  endtask

  // Press and hold; returns just after the edge where the first step lands.
  task automatic push(input logic u, input logic d, input logic c);
    btn_up = u; btn_down = d; btn_clr = c;
    tick(13);
  endtask

  task automatic run_until(input string tag, input bit use_bcd, input logic [15:0] target);
    for (int i = 0; i < 20000; i++) begin
      if ((use_bcd ? dw_bcd : dw_hex) == target) break;
      tick(1);
    end
    chk(tag, use_bcd ? dw_bcd : dw_hex, target);
  endtask

  initial begin
    rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    tick(3);
    chk("rst_dw_hex", dw_hex, 16'h0000);
    chk("rst_dw_bcd", dw_bcd, 16'h0000);
    chk("rst_wrap_hex", wrap_hex, 16'h0);
    chk("rst_wrap_bcd", wrap_bcd, 16'h0);
    rst_n = 1'b1;
    tick(2);

    // Bounce: 10 segments of 3 cycles, then a final rise held high.
    for (int i = 0; i < 10; i++) begin
      btn_up = (i % 2 == 0);
      tick(3);
    end
    chk("bounce_none", dw_hex, 16'h0000);
    btn_up = 1'b1;
    tick(12);
    chk("bounce_e11", dw_hex, 16'h0000);
    tick(1);
    chk("bounce_e12_hex", dw_hex, 16'h0001);
    chk("bounce_e12_bcd", dw_bcd, 16'h0001);
    release_all();
    chk("bounce_once", dw_hex, 16'h0001);

    // Clear, then auto-repeat: steps at edges 12, 52, 62, ... 102.
    push(1'b0, 1'b0, 1'b1);
    chk("clr", dw_hex, 16'h0000);
    release_all();
    btn_up = 1'b1;
    tick(52);
    chk("rep_e51", dw_hex, 16'h0001);
    tick(1);
    chk("rep_e52", dw_hex, 16'h0002);
    tick(47);
    chk("rep_e99", dw_hex, 16'h0006);
    btn_up = 1'b0;
    tick(60);
    chk("rep_end_hex", dw_hex, 16'h0007);
    chk("rep_end_bcd", dw_bcd, 16'h0007);

    // Wrap in both directions on both counters.
    push(1'b0, 1'b0, 1'b1);
    release_all();
    push(1'b0, 1'b1, 1'b0);
    chk("dn_wrap_hex", dw_hex, 16'hFFFF);
    chk("dn_wrap_hex_w", wrap_hex, 16'h1);
    chk("dn_wrap_bcd", dw_bcd, 16'h9999);
    chk("dn_wrap_bcd_w", wrap_bcd, 16'h1);
    tick(1);
    chk("dn_wrap_pulse", wrap_hex, 16'h0);
    release_all();
    push(1'b0, 1'b1, 1'b0);
    chk("dn_hex_fffe", dw_hex, 16'hFFFE);
    release_all();
    push(1'b1, 1'b0, 1'b0);
    chk("up_hex_ffff", dw_hex, 16'hFFFF);
    chk("up_hex_ffff_w", wrap_hex, 16'h0);
    chk("up_bcd_9999", dw_bcd, 16'h9999);
    release_all();
    push(1'b1, 1'b0, 1'b0);
    chk("up_wrap_hex", dw_hex, 16'h0000);
    chk("up_wrap_hex_w", wrap_hex, 16'h1);
    chk("up_wrap_bcd", dw_bcd, 16'h0000);
    chk("up_wrap_bcd_w", wrap_bcd, 16'h1);
    tick(1);
    chk("up_wrap_pulse", wrap_bcd, 16'h0);
    release_all();

    // BCD carries; releasing on a step lets exactly one more repeat step land.
    push(1'b0, 1'b0, 1'b1);
    release_all();
    btn_up = 1'b1;
    run_until("reach_0098", 1'b1, 16'h0098);
    btn_up = 1'b0;
    tick(30);
    chk("bcd_0099", dw_bcd, 16'h0099);
    push(1'b1, 1'b0, 1'b0);
    chk("bcd_carry_0100", dw_bcd, 16'h0100);
    release_all();
    btn_up = 1'b1;
    run_until("reach_0999", 1'b1, 16'h0999);
    btn_up = 1'b0;
    tick(30);
    chk("bcd_carry_1000", dw_bcd, 16'h1000);
    push(1'b0, 1'b1, 1'b0);
    chk("bcd_borrow_0999", dw_bcd, 16'h0999);
    release_all();

    // Priority: clear beats up; simultaneous up+down does nothing.
    push(1'b1, 1'b0, 1'b1);
    chk("prio_clr_hex", dw_hex, 16'h0000);
    chk("prio_clr_bcd", dw_bcd, 16'h0000);
    chk("prio_clr_w", wrap_hex, 16'h0);
    release_all();
    push(1'b1, 1'b0, 1'b0);
    release_all();
    push(1'b1, 1'b1, 1'b0);
    chk("prio_updn", dw_hex, 16'h0001);
    tick(50);
    chk("prio_updn_hold", dw_bcd, 16'h0001);
    release_all();

    // Asynchronous reset in REPEAT; held button debounces afresh afterward.
    push(1'b0, 1'b0, 1'b1);
    release_all();
    btn_up = 1'b1;
    run_until("reach_0042", 1'b0, 16'h0042);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hex", dw_hex, 16'h0000);
    chk("async_rst_bcd", dw_bcd, 16'h0000);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("post_rst_e11", dw_hex, 16'h0000);
    tick(1);
    chk("post_rst_e12", dw_hex, 16'h0001);
    tick(39);
    chk("post_rst_e51", dw_hex, 16'h0001);
    tick(1);
    chk("post_rst_e52", dw_hex, 16'h0002);
    release_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
